div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider serving the EX stage for DIV/DIVU.
//  EX raises start_i with operands, stalls the pipeline until ready_o, then
//  writes result_o {remainder, quotient} into HI/LO through the whilo path.
//  Width-parametrised; signed/unsigned selectable per operation; annullable.
// PARAMETERS
//  WIDTH   32   operand width in bits; result_o is 2*WIDTH, counter is clog2(WIDTH)+1 bits
// PORTS
//  clk          in   1        clock; all state changes on rising edge
//  rst          in   1        synchronous, active-high reset
//  signed_div_i in   1        1 = two's-complement divide, 0 = unsigned
//  opdata1_i    in   WIDTH    dividend; sampled only on accepted start
//  opdata2_i    in   WIDTH    divisor; sampled only on accepted start
//  start_i      in   1        request; held high by EX until ready_o seen
//  annul_i      in   1        abort in-flight divide (branch/exception flush)
//  result_o     out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
//  ready_o      out  1        result_o valid
// BEHAVIOUR
//  - One clock, synchronous active-high reset. rst=1: state IDLE, ready_o=0,
//    result_o=0, counter=0, internal operands cleared. Reset mid-divide aborts silently.
//  - All outputs registered. States: IDLE, BYZERO, ON, END.
//  - IDLE: start_i=1 & annul_i=0 -> latch operands, clear counter.
//      divisor==0 -> BYZERO; else -> ON. start_i=0 or annul_i=1 -> stay IDLE.
//  - Signed mode: latch |dividend|, |divisor|; record sign(dividend) and
//    sign(dividend)^sign(divisor). Unsigned mode: latch raw values.
//  - ON: one restoring step per cycle: shift partial remainder left, bring in
//    next dividend bit MSB-first, trial-subtract divisor (WIDTH+1-bit compare),
//    quotient bit = 1 if non-negative. Counter increments; after WIDTH steps
//    (counter==WIDTH) next edge -> END with ready_o=1 and result_o loaded.
//  - annul_i=1 in ON -> IDLE next edge, ready_o stays 0, result_o unchanged (0).
//  - BYZERO: next edge -> END, result_o=0, ready_o=1 (architecturally undefined; fixed 0).
//  - Signed correction at END load: quotient negated if sign-xor set; remainder
//    negated if dividend negative (remainder sign follows dividend).
//  - Overflow MIN/-1 (signed): quotient=MIN (wraps), remainder=0; no trap.
//  - Latency: ready_o rises WIDTH+2 edges after the edge accepting start_i
//    (2 edges for divide-by-zero).
//  - END: hold ready_o=1, result_o stable while start_i=1. start_i=0 -> IDLE
//    next edge, ready_o=0, result_o=0. annul_i ignored in END and BYZERO.
//  - Operand changes after acceptance have no effect. start_i re-high in the
//    same cycle END->IDLE is not possible (EX drops start first); new request
//    accepted from IDLE the following cycle.
// TESTING
//  1 unsigned 100/7, start held -> ready_o at edge 34, result_o={32'd2,32'd14}
//  2 signed -100/7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2);
//    signed 100/-7 -> q=-14, r=+2; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0
//  3 divisor 0 (either mode) -> ready_o after 2 edges, result_o=0; drop start -> IDLE, ready_o=0
//  4 signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, no X, latency 34
//  5 annul_i pulse at step 10 -> ready_o never rises, back in IDLE; next 9/3 -> q=3, r=0
//  6 rst at step 20 -> outputs 0 next edge; WIDTH=8: 200/13 -> q=15, r=5, ready at edge 10

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient}, with optional two's-complement handling and annul.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               a_neg, b_neg;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign result_o = result_q;
    assign ready_o  = ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        a_neg = signed_div_i & opdata1_i[WIDTH-1];
        b_neg = signed_div_i & opdata2_i[WIDTH-1];
        // Partial remainder shifted with the next dividend bit, minus divisor; MSB is the borrow.
        trial = {1'b0, rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
        q_fix = neg_quo_q ? WIDTH'(-quo_q) : quo_q;
        r_fix = neg_rem_q ? WIDTH'(-rem_q) : rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    dvd_d     = a_neg ? WIDTH'(-opdata1_i) : opdata1_i;
                    dvs_d     = b_neg ? WIDTH'(-opdata2_i) : opdata2_i;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = '0;
                    state_d   = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                state_d = ST_END;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d = ST_END;
                end else begin
                    // On borrow the partial remainder is below the divisor, so its top bit is free.
                    rem_d = trial[WIDTH+1] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]}
                                           : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_END: begin
                if (start_i) begin
                    ready_d  = 1'b1;
                    result_d = {r_fix, q_fix};
                end else begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

endmodule
